trace_arb: RTL and testbench
============================

// Module: trace_arb
// PURPOSE
//  Shares one trace_ring record stream among N_SRC trace producers (cores, DMA, bus monitors).
//  Round-robin arbitration with a registered output stage.
//  Overwrites each record's source-ID field with the source index.
//  Optional lossy mode drops records instead of back-pressuring producers.
//  Sits between the per-unit trace taps and trace_ring's trace_valid/ready/data input.
// PARAMETERS
//  N_SRC     4    number of requesting trace sources (2..8)
//  REC_W     128  record width in bits, equal to trace_ring REC_W
//  SRC_ID_W  3    width of source-ID field at rec[REC_W-1 -: SRC_ID_W]; must hold N_SRC-1
//  DROP_W    16   per-source drop counter width (saturating)
// PORTS
//  clk         in   1             clock
//  rst_n       in   1             async active-low reset
//  src_en      in   N_SRC         per-source enable mask (quasi-static)
//  lossy       in   1             1 = drop on contention/full, 0 = back-pressure
//  src_valid   in   N_SRC         record offered by source i
//  src_ready   out  N_SRC         record from source i consumed (granted or discarded)
//  src_data    in   N_SRC*REC_W   records, source i at [i*REC_W +: REC_W]
//  out_valid   out  1             to trace_ring trace_valid
//  out_ready   in   1             from trace_ring trace_ready
//  out_data    out  REC_W         to trace_ring trace_data
//  drop_clr    in   1             single-cycle pulse, clears all drop counters
//  drop_cnt    out  N_SRC*DROP_W  per-source dropped-record counts
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, rr_ptr=0, all drop_cnt=0.
//   src_ready is combinational; it is 0 when src_valid=0 for every enabled source.
//  Output stage: one register. load_en = !out_valid_q || out_ready; handshake holds data stable
//   while out_valid && !out_ready. Latency src handshake -> out_valid = 1 cycle.
//   Full throughput is one record per cycle.
//  Arbitration: contenders = src_valid & src_en. When load_en and any contender exists, grant the
//   first contender at or after rr_ptr, wrapping N_SRC-1 -> 0. Then src_ready[g]=1,
//   load out_data from rec_g with ID field := g, and set rr_ptr := g+1, wrapping to 0.
//   rr_ptr is unchanged when there is no grant.
//  Disabled source (src_en[i]=0): src_ready[i]=1. Record discarded, not counted.
//   Producers never hang with tracing off.
//  Lossless (lossy=0): non-granted contenders see src_ready=0 and hold their data.
//  Lossy (lossy=1): src_ready[i]=1 for every enabled valid source. Each non-granted contender,
//   including all contenders when load_en=0, is dropped and its drop_cnt increments.
//  Drop counters saturate at all-ones.
//   drop_clr and increment in the same cycle: clear wins (result 0).
//  Toggling lossy or src_en mid-stream affects only the next arbitration.
//   The record in the output register is never discarded.
//  Reset mid-transfer: the output record is lost and out_valid drops asynchronously.
//   trace_ring resets on the same rst_n.
// CONFIGURATION
//  CARBON_TRACE_ARB_DROP_CNT_EN defined: drop counters are implemented as above.
//  Not defined: no counter flops; drop_cnt tied to 0 and drop_clr ignored.
//   Lossy dropping behaviour is unchanged.
// STRUCTURE
//  carbon_arch_pkg gains:
//   - CARBON_TRACE_SRC_ID_W (default for SRC_ID_W)
//   - CARBON_TRACE_SRC_* enumerated source indices
//   - function trace_set_src(rec, id), reused by the trace decoder and the bench
//  Sub-module trace_rr_pick: combinational round-robin priority pick (req, ptr -> gnt one-hot,
//   gnt_idx, any); rr_ptr flop stays in trace_arb.
// TESTING
//  1. Single source: src0 sends 0xA5.., out_ready=1.
//     -> out_valid next cycle; ID field=0; one record per cycle over 10 records.
//  2. Four sources valid continuously, lossless, out_ready=1.
//     -> grant order 0,1,2,3,0,...; each src_ready duty 1/4; no drops.
//  3. Back-pressure: out_ready=0 for 5 cycles with src1 valid, lossless.
//     -> out_data stable; src_ready[1]=0 throughout; resumes on out_ready=1.
//  4. Lossy: out_ready=0 for 5 cycles, src2 valid every cycle.
//     -> src_ready[2]=1; drop_cnt[2]=5 (plus 1 for any overlap with buffered grant).
//  5. drop_cnt saturation with DROP_W=4: 20 drops -> 15. drop_clr with a same-cycle drop -> 0.
//  6. src_en=4'b1110 with src0 valid.
//     -> src_ready[0]=1, no output record, drop_cnt[0] stays 0.
//     Then rst_n low mid-stream -> out_valid=0 at once.

Source files
------------

// File: rtl/carbon_arch_pkg.sv
// carbon_arch_pkg: shared trace constants, source indices and record ID helper.
package carbon_arch_pkg;
  localparam int CARBON_TRACE_SRC_ID_W = 3;
  localparam int CARBON_TRACE_REC_W = 128;
  typedef enum logic [CARBON_TRACE_SRC_ID_W-1:0] {
    CARBON_TRACE_SRC_CORE0  = 3'd0,
    CARBON_TRACE_SRC_CORE1  = 3'd1,
    CARBON_TRACE_SRC_DMA    = 3'd2,
    CARBON_TRACE_SRC_BUSMON = 3'd3
  } trace_src_e;
  function automatic logic [CARBON_TRACE_REC_W-1:0] trace_set_src(
    input logic [CARBON_TRACE_REC_W-1:0] rec,
    input logic [CARBON_TRACE_SRC_ID_W-1:0] id
  );
    return {id, rec[CARBON_TRACE_REC_W-CARBON_TRACE_SRC_ID_W-1:0]};
  endfunction
endpackage

// File: rtl/trace_rr_pick.sv
// trace_rr_pick: combinational round-robin pick of the first request at or after ptr.
module trace_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);
  // Scan from farthest to nearest so the last hit is the one closest to ptr.
  always_comb begin
    gnt_idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt_idx = PW'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    end
    gnt = any ? N'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/trace_arb.sv
// trace_arb: round-robin merge of trace sources into one registered record stream.
// Drop counters exist only when CARBON_TRACE_ARB_DROP_CNT_EN is defined.
module trace_arb
  import carbon_arch_pkg::*;
#(
  parameter int N_SRC    = 4,
  parameter int REC_W    = 128,
  parameter int SRC_ID_W = CARBON_TRACE_SRC_ID_W,
  parameter int DROP_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_SRC-1:0]        src_en,
  input  logic                    lossy,
  input  logic [N_SRC-1:0]        src_valid,
  output logic [N_SRC-1:0]        src_ready,
  input  logic [N_SRC*REC_W-1:0]  src_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [REC_W-1:0]        out_data,
  input  logic                    drop_clr,
  output logic [N_SRC*DROP_W-1:0] drop_cnt
);
  localparam int PW = N_SRC > 1 ? $clog2(N_SRC) : 1;
  logic [N_SRC-1:0] contenders, gnt, drop;
  logic [PW-1:0] gnt_idx, rr_ptr;
  logic any, load_en;
  logic [REC_W-1:0] rec_g;
  assign contenders = src_valid & src_en;
  assign load_en = !out_valid || out_ready;
  trace_rr_pick #(.N(N_SRC), .PW(PW)) u_pick (
    .req(load_en ? contenders : '0),
    .ptr(rr_ptr),
    .gnt(gnt),
    .gnt_idx(gnt_idx),
    .any(any)
  );
  // Disabled sources are always drained so producers never stall with tracing off.
  assign src_ready = ~src_en | (lossy ? contenders : gnt);
  assign drop = lossy ? contenders & ~gnt : '0;
  assign rec_g = src_data[gnt_idx*REC_W +: REC_W];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      rr_ptr <= '0;
    end else begin
      if (load_en) out_valid <= any;
      if (any) begin
        out_data <= {SRC_ID_W'(gnt_idx), rec_g[REC_W-SRC_ID_W-1:0]};
        rr_ptr <= gnt_idx == PW'(N_SRC - 1) ? '0 : gnt_idx + PW'(1);
      end
    end
  end
`ifdef CARBON_TRACE_ARB_DROP_CNT_EN
  for (genvar i = 0; i < N_SRC; i++) begin : g_cnt
    logic [DROP_W-1:0] c;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) c <= '0;
      else if (drop_clr) c <= '0;
      else if (drop[i] && c != '1) c <= c + DROP_W'(1);
    end
    assign drop_cnt[i*DROP_W +: DROP_W] = c;
  end
`else
  logic unused_drop;
  assign unused_drop = ^{drop_clr, drop};
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_trace_arb.sv
// tb_trace_arb: directed vectors for trace_arb with hand-computed expectations.
module tb_trace_arb;
  import carbon_arch_pkg::*;
  localparam int N = 4, W = 128, DW = 4;
`ifdef CARBON_TRACE_ARB_DROP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, lossy = 1'b0, out_ready = 1'b0, drop_clr = 1'b0, out_valid;
  logic [N-1:0] src_en = '1, src_valid = '0, src_ready;
  logic [N*W-1:0] src_data = '0;
  logic [W-1:0] out_data, held;
  logic [N*DW-1:0] drop_cnt;
  int n_vec = 0, n_err = 0;

  trace_arb #(.N_SRC(N), .REC_W(W), .DROP_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .src_en(src_en), .lossy(lossy),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_clr(drop_clr), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_valid = '0;
    src_en = '1;
    lossy = 1'b0;
    out_ready = 1'b1;
    drop_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [W-1:0] mk(input int k);
    return {16{8'hA5}} ^ W'(k * 32'h01010101);
  endfunction

  initial begin
    // reset state
    #3;
    chk("rst_out_valid", W'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_drop_cnt", W'(drop_cnt), 0);
    do_reset();

    // single source, ten back-to-back records
    src_valid = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      src_data[0 +: W] = mk(k);
      #1 chk("t1_ready", W'(src_ready), W'(4'b0001));
      step();
      chk("t1_valid", W'(out_valid), 1);
      chk("t1_data", out_data, trace_set_src(mk(k), 3'd0));
    end
    src_valid = '0;
    step();
    chk("t1_idle", W'(out_valid), 0);

    // four sources, lossless rotation
    do_reset();
    for (int i = 0; i < N; i++) src_data[i*W +: W] = mk(i + 20);
    src_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1 chk("t2_ready", W'(src_ready), W'(4'b0001 << (k % 4)));
      step();
      chk("t2_data", out_data, trace_set_src(mk(k % 4 + 20), 3'(k % 4)));
    end
    src_valid = '0;
    chk("t2_nodrop", W'(drop_cnt), 0);

    // lossless back-pressure
    do_reset();
    src_valid = 4'b0010;
    src_data[W +: W] = mk(40);
    #1 chk("t3_ready0", W'(src_ready), W'(4'b0010));
    step();
    out_ready = 1'b0;
    src_data[W +: W] = mk(41);
    for (int k = 0; k < 5; k++) begin
      #1 chk("t3_stall_ready", W'(src_ready), 0);
      chk("t3_hold_data", out_data, trace_set_src(mk(40), 3'd1));
      chk("t3_hold_valid", W'(out_valid), 1);
      step();
    end
    out_ready = 1'b1;
    #1 chk("t3_resume_ready", W'(src_ready), W'(4'b0010));
    step();
    chk("t3_resume_data", out_data, trace_set_src(mk(41), 3'd1));
    src_valid = '0;

    // lossy with full output: first record buffered, next five dropped
    do_reset();
    lossy = 1'b1;
    out_ready = 1'b0;
    src_valid = 4'b0100;
    src_data[2*W +: W] = mk(60);
    for (int k = 0; k < 6; k++) begin
      #1 chk("t4_ready", W'(src_ready), W'(4'b0100));
      step();
      src_data[2*W +: W] = mk(61 + k);
    end
    src_valid = '0;
    step();
    chk("t4_drops", W'(drop_cnt[2*DW +: DW]), CNT_EN ? W'(5) : W'(0));
    chk("t4_other_cnt", W'(drop_cnt), CNT_EN ? W'(5) << (2*DW) : W'(0));
    chk("t4_kept", out_data, trace_set_src(mk(60), 3'd2));
    chk("t4_valid", W'(out_valid), 1);

    // saturation then clear colliding with a drop
    src_valid = 4'b0100;
    repeat (20) step();
    chk("t5_sat", W'(drop_cnt[2*DW +: DW]), CNT_EN ? W'(15) : W'(0));
    drop_clr = 1'b1;
    step();
    chk("t5_clr_wins", W'(drop_cnt[2*DW +: DW]), 0);
    drop_clr = 1'b0;
    src_valid = '0;
    step();
    chk("t5_clr_stays", W'(drop_cnt), 0);

    // disabled source is drained without output or count
    do_reset();
    src_en = 4'b1110;
    src_valid = 4'b0001;
    #1 chk("t6_ready", W'(src_ready), W'(4'b0001));
    step();
    chk("t6_no_out", W'(out_valid), 0);
    lossy = 1'b1;
    step();
    chk("t6_no_out_lossy", W'(out_valid), 0);
    chk("t6_no_cnt", W'(drop_cnt), 0);

    // asynchronous reset mid-stream
    src_en = '1;
    lossy = 1'b0;
    out_ready = 1'b0;
    step();
    chk("t6_loaded", W'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1 chk("t6_async_rst", W'(out_valid), 0);
    chk("t6_async_data", out_data, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
